// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU plus optional iterative multiply, registered writeback.
// Build option ALU_MUL_EN enables the shift-add multiply (op 9); otherwise op 9 is a NOP.
module alu_exec #(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic [RW-1:0] dst_in,
    output logic          wb_we,
    output logic [RW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd10;

    logic          wb_we_q;
    logic [RW-1:0] wb_dst_q;
    logic [DW-1:0] wb_data_q;
    logic          flag_z_q;
    logic          flag_c_q;

    logic [DW:0]   ext_d;
    logic [DW-1:0] alu_res_d;
    logic          alu_c_d;
    logic          alu_wr_d;

    // Single-cycle result; everything is computed DW+1 bits wide so the carry falls out naturally.
    always_comb begin
        ext_d     = '0;
        alu_res_d = '0;
        alu_c_d   = flag_c_q;
        alu_wr_d  = 1'b0;
        unique case (op)
            OP_ADD: begin
                ext_d    = {1'b0, src_a} + {1'b0, src_b};
                alu_wr_d = 1'b1;
            end
            OP_SUB: begin
                ext_d    = {1'b0, src_a} - {1'b0, src_b};
                alu_wr_d = 1'b1;
            end
            OP_ADC: begin
                ext_d    = {1'b0, src_a} + {1'b0, src_b} + (DW+1)'(flag_c_q);
                alu_wr_d = 1'b1;
            end
            OP_AND: begin ext_d = {1'b0, src_a & src_b}; alu_wr_d = 1'b1; end
            OP_OR:  begin ext_d = {1'b0, src_a | src_b}; alu_wr_d = 1'b1; end
            OP_XOR: begin ext_d = {1'b0, src_a ^ src_b}; alu_wr_d = 1'b1; end
            OP_NOT: begin ext_d = {1'b0, ~src_a};        alu_wr_d = 1'b1; end
            OP_SHL: begin ext_d = {src_a, 1'b0};         alu_wr_d = 1'b1; end
            OP_SHR: begin ext_d = {src_a[0], 1'b0, src_a[DW-1:1]}; alu_wr_d = 1'b1; end
            OP_MOV: begin ext_d = {flag_c_q, src_b};     alu_wr_d = 1'b1; end
            default: ;
        endcase
        alu_res_d = ext_d[DW-1:0];
        if (alu_wr_d) alu_c_d = ext_d[DW];
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0]  OP_MUL = 4'd9;
    localparam int unsigned CW     = $clog2(DW + 1);
    localparam int unsigned PW     = 2 * DW;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] acc_q;
    logic [PW-1:0] a_sh_q;
    logic [DW-1:0] b_sh_q;
    logic [RW-1:0] mdst_q;
    logic          ready_q;
    logic          busy_q;
    logic [PW-1:0] acc_d;

    assign acc_d    = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
    assign in_ready = ready_q;
    assign busy     = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            mdst_q    <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            wb_we_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && op == OP_MUL) begin
                        state_q <= S_MUL;
                        cnt_q   <= CW'(DW);
                        acc_q   <= '0;
                        a_sh_q  <= PW'(src_a);
                        b_sh_q  <= src_b;
                        mdst_q  <= dst_in;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (in_valid && alu_wr_d) begin
                        wb_we_q   <= 1'b1;
                        wb_dst_q  <= dst_in;
                        wb_data_q <= alu_res_d;
                        flag_z_q  <= (alu_res_d == '0);
                        flag_c_q  <= alu_c_d;
                    end
                end
                S_MUL: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_q >> 1;
                    cnt_q  <= cnt_q - CW'(1);
                    // Last iteration: the final partial sum goes straight to writeback.
                    if (cnt_q == CW'(1)) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        wb_we_q   <= 1'b1;
                        wb_dst_q  <= mdst_q;
                        wb_data_q <= acc_d[DW-1:0];
                        flag_z_q  <= (acc_d[DW-1:0] == '0);
                        flag_c_q  <= |acc_d[PW-1:DW];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            wb_we_q <= 1'b0;
            if (in_valid && alu_wr_d) begin
                wb_we_q   <= 1'b1;
                wb_dst_q  <= dst_in;
                wb_data_q <= alu_res_d;
                flag_z_q  <= (alu_res_d == '0);
                flag_c_q  <= alu_c_d;
            end
        end
    end
`endif

    assign wb_we   = wb_we_q;
    assign wb_dst  = wb_dst_q;
    assign wb_data = wb_data_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute stage directly downstream of the 16x8 register file.
- Consumes the two read operands (data0/data1) plus a decoded opcode and destination index.
- Computes the result and drives the register-file write port (we/dst/data) through a registered writeback.
- Single-cycle ALU ops, plus an iterative shift-add multiply behind a valid/ready handshake.
- Holds Z/C status flags for the branch unit.

Parameters:
DW, 8, datapath width (matches register width)
RW, 4, register index width (16 registers)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  opcode/operands valid this cycle
in_ready  output  1  stage can accept; high only in IDLE
op  input  4  opcode (see Behaviour)
src_a  input  DW  operand A (register file data0)
src_b  input  DW  operand B (register file data1)
dst_in  input  RW  destination register index
wb_we  output  1  register file write enable, one-cycle pulse
wb_dst  output  RW  register file write index
wb_data  output  DW  register file write data
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow/overflow flag
busy  output  1  multiply in progress

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0, except in_ready = 1. State is IDLE; internal counter and accumulator are 0.
- Accept: in_valid && in_ready sampled at rising edge k.
- Opcodes:
  - 0 ADD: a+b, C = carry out
  - 1 SUB: a-b, C = borrow (a<b)
  - 2 AND, 3 OR, 4 XOR: C = 0
  - 5 NOT: ~a, C = 0
  - 6 SHL: a<<1, C = a[DW-1]
  - 7 SHR: a>>1 logical, C = a[0]
  - 8 MOV: b, C unchanged
  - 9 MUL: low DW bits of a*b, C = 1 if the high DW bits are nonzero
  - 10 ADC: a+b+flag_c, C = carry out
  - 11-15 NOP: no writeback, flags unchanged, in_ready stays high
- Single-cycle ops:
  - wb_we, wb_dst, wb_data, flags all registered at edge k.
  - Visible in the cycle after edge k; latency 1.
  - Back-to-back accepts every cycle are allowed.
- All arithmetic is DW+1 bits internally; wb_data is the low DW bits. Z = (wb_data == 0) for every writing op.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accept of op 9. Latch a, b, dst_in; acc = 0; cnt = DW.
  - MUL: on each edge, if b_shift[0] then acc += a_shift; a_shift <<= 1; b_shift >>= 1; cnt--.
  - MUL -> IDLE on the edge where cnt reaches 0. wb_we/wb_data/flags are registered on that same edge.
  - MUL writeback is visible after edge k+DW (8 cycles for DW=8).
  - in_ready = 0 and busy = 1 throughout MUL. in_valid is ignored while busy.
- wb_we is high for exactly one cycle per writing op, never otherwise. wb_dst/wb_data hold their last values when wb_we = 0.
- Reset mid-multiply: immediate abort, no writeback, flags cleared, return to IDLE.
- MUL by 0: still runs the full DW cycles and writes 0 with Z=1, C=0.
- Same src and dst register is allowed: operands are sampled before the write lands.

Optional Feature:
ALU_MUL_EN
- Defined: op 9 is the iterative multiply as above.
- Undefined: no MUL state, counter or accumulator is built. op 9 is a NOP, in_ready is tied to 1 and busy to 0.

Test Plan:
- Reset asserted mid-cycle: all outputs 0 and in_ready = 1 immediately, with no clock edge needed.
- ADD a=0xF0, b=0x20, dst=3: next cycle wb_we=1, wb_dst=3, wb_data=0x10, C=1, Z=0.
- SUB a=0x05, b=0x05, then ADC a=0x01, b=0x01 on consecutive cycles: first wb_data=0x00, Z=1, C=0; then wb_data=0x02, C=0.
- MUL a=0x12, b=0x10, dst=7: busy for 8 cycles, in_valid ignored during them; wb_data=0x20, C=1 after edge k+8; in_ready returns to 1.
- rst pulsed at cycle 4 of a MUL: no wb_we pulse at any time, flags 0, next ADD accepted normally.
- op 12 (NOP) followed by SHR a=0x01: no wb_we for the NOP; then wb_data=0x00, Z=1, C=1.
